// File: rtl/cfg_pkg.sv
// cfg_pkg: default geometry of the hash table
package cfg_pkg;
  localparam int D_N_SETS = 16;
  localparam int D_N_WAYS = 4;
  localparam int D_K_W    = 32;
  localparam int D_V_W    = 32;
endpackage

// File: rtl/h_pkg.sv
// h_pkg: command and response encodings of the hash table
package h_pkg;
  typedef enum logic [2:0] {
    NOP    = 3'd0,
    INSERT = 3'd1,
    DELETE = 3'd2,
    QUERY  = 3'd3,
    CLEAR  = 3'd4
  } opcode_t;
  typedef enum logic [2:0] {
    OK    = 3'd0,
    HIT   = 3'd1,
    MISS  = 3'd2,
    FULL  = 3'd3,
    EVICT = 3'd4,
    BADOP = 3'd5
  } status_t;
endpackage

// File: rtl/h_assoc_tbl.sv
// h_assoc_tbl: per-set storage of valid/key/value and round-robin pointer
module h_assoc_tbl #(
  parameter int N_SETS = 16,
  parameter int N_WAYS = 4,
  parameter int K_W = 32,
  parameter int V_W = 32,
  localparam int S_W = $clog2(N_SETS),
  localparam int P_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [S_W-1:0]    rd_set,
  output logic [N_WAYS-1:0] rd_valid,
  output logic [K_W-1:0]    rd_key [N_WAYS],
  output logic [V_W-1:0]    rd_val [N_WAYS],
  output logic [P_W-1:0]    rd_ptr,
  input  logic              wr_en,
  input  logic [S_W-1:0]    wr_set,
  input  logic [P_W-1:0]    wr_way,
  input  logic              wr_valid,
  input  logic [K_W-1:0]    wr_key,
  input  logic [V_W-1:0]    wr_val,
  input  logic              ptr_adv,
  input  logic              clr_en,
  input  logic [S_W-1:0]    clr_set
);
  logic [N_WAYS-1:0] valid [N_SETS];
  logic [P_W-1:0]    ptr   [N_SETS];
  logic [K_W-1:0]    keys  [N_SETS][N_WAYS];
  logic [V_W-1:0]    vals  [N_SETS][N_WAYS];
  // control state: valid bits and eviction pointers, cleared by reset or one set at a time
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      for (int i = 0; i < N_SETS; i++) begin
        valid[i] <= '0;
        ptr[i]   <= '0;
      end
    end else if (clr_en) begin
      valid[clr_set] <= '0;
      ptr[clr_set]   <= '0;
    end else begin
      if (wr_en) valid[wr_set][wr_way] <= wr_valid;
      if (ptr_adv) ptr[wr_set] <= (ptr[wr_set] == P_W'(N_WAYS - 1)) ? '0 : ptr[wr_set] + 1'b1;
    end
  // payload storage is never reset; a delete only drops the valid bit
  always_ff @(posedge clk)
    if (wr_en && wr_valid) begin
      keys[wr_set][wr_way] <= wr_key;
      vals[wr_set][wr_way] <= wr_val;
    end
  // combinational read of one whole set
  always_comb begin
    rd_valid = valid[rd_set];
    rd_ptr   = ptr[rd_set];
    for (int w = 0; w < N_WAYS; w++) begin
      rd_key[w] = keys[rd_set][w];
      rd_val[w] = vals[rd_set][w];
    end
  end
endmodule

// File: rtl/h_assoc.sv
// h_assoc: set-associative key/value table with external hash
module h_assoc
  import h_pkg::*;
#(
  parameter int N_SETS = cfg_pkg::D_N_SETS,
  parameter int N_WAYS = cfg_pkg::D_N_WAYS,
  parameter int K_W = cfg_pkg::D_K_W,
  parameter int V_W = cfg_pkg::D_V_W,
  parameter int EVICT_EN = 0,
  localparam int S_W = $clog2(N_SETS),
  localparam int P_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  opcode_t        cmd_opcode,
  input  logic [K_W-1:0] cmd_k,
  input  logic [V_W-1:0] cmd_v,
  output logic           rsp_vld,
  output status_t        rsp_status,
  output logic [V_W-1:0] rsp_v,
  output logic [K_W-1:0] hash_k,
  input  logic [S_W-1:0] hash_h
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, CLR} state_t;
  state_t            state;
  opcode_t           r_op;
  logic [K_W-1:0]    r_key;
  logic [V_W-1:0]    r_val;
  logic [S_W-1:0]    r_set;
  logic [S_W-1:0]    cnt;
  logic [N_WAYS-1:0] rd_valid;
  logic [K_W-1:0]    rd_key [N_WAYS];
  logic [V_W-1:0]    rd_val [N_WAYS];
  logic [P_W-1:0]    rd_ptr;
  logic [N_WAYS-1:0] hit_vec;
  logic [P_W-1:0]    hw;
  logic [P_W-1:0]    iw;
  logic              any_hit;
  logic              full;
  logic              wr_en;
  logic              wr_valid;
  logic              ptr_adv;
  logic [P_W-1:0]    wr_way;
  status_t           n_st;
  logic [V_W-1:0]    n_v;
  logic              acc;
  assign hash_k  = cmd_k;
  assign cmd_rdy = (state == IDLE) || (state == RESP);
  assign rsp_vld = (state == RESP);
  assign acc     = cmd_vld && cmd_rdy;
  // parallel compare; descending scan leaves the lowest matching / free way
  always_comb begin
    hw = '0;
    iw = '0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = rd_valid[w] && (rd_key[w] == r_key);
      if (hit_vec[w]) hw = P_W'(w);
      if (!rd_valid[w]) iw = P_W'(w);
    end
    any_hit = |hit_vec;
    full    = &rd_valid;
  end
  // per-opcode outcome: table write, pointer advance and response
  always_comb begin
    wr_en    = 1'b0;
    wr_valid = 1'b1;
    ptr_adv  = 1'b0;
    wr_way   = hw;
    n_st     = BADOP;
    n_v      = '0;
    if (r_op == QUERY) begin
      n_st = any_hit ? HIT : MISS;
      n_v  = any_hit ? rd_val[hw] : '0;
    end else if (r_op == DELETE) begin
      n_st     = any_hit ? HIT : MISS;
      n_v      = any_hit ? rd_val[hw] : '0;
      wr_en    = any_hit;
      wr_valid = 1'b0;
    end else if (r_op == INSERT) begin
      if (any_hit) begin
        wr_en = 1'b1;
        n_st  = HIT;
        n_v   = rd_val[hw];
      end else if (!full) begin
        wr_en  = 1'b1;
        wr_way = iw;
        n_st   = OK;
      end else if (EVICT_EN != 0) begin
        wr_en   = 1'b1;
        wr_way  = rd_ptr;
        ptr_adv = 1'b1;
        n_st    = EVICT;
        n_v     = rd_val[rd_ptr];
      end else n_st = FULL;
    end
  end
  // FSM with registered response; status/value only change on entering RESP
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_status <= OK;
      rsp_v      <= '0;
    end else if (state == LOOKUP) begin
      state      <= RESP;
      rsp_status <= n_st;
      rsp_v      <= n_v;
    end else if (state == CLR) begin
      cnt <= cnt + 1'b1;
      if (cnt == S_W'(N_SETS - 1)) begin
        state      <= RESP;
        rsp_status <= OK;
        rsp_v      <= '0;
      end
    end else if (acc) state <= (cmd_opcode == NOP) ? IDLE : (cmd_opcode == CLEAR) ? CLR : LOOKUP;
    else state <= IDLE;
  // command capture at acceptance
  always_ff @(posedge clk)
    if (acc) begin
      r_op  <= cmd_opcode;
      r_key <= cmd_k;
      r_val <= cmd_v;
      r_set <= hash_h;
    end
  h_assoc_tbl #(.N_SETS(N_SETS), .N_WAYS(N_WAYS), .K_W(K_W), .V_W(V_W)) u_tbl (
    .clk      (clk),
    .arst_n   (arst_n),
    .rd_set   (r_set),
    .rd_valid (rd_valid),
    .rd_key   (rd_key),
    .rd_val   (rd_val),
    .rd_ptr   (rd_ptr),
    .wr_en    (wr_en && (state == LOOKUP)),
    .wr_set   (r_set),
    .wr_way   (wr_way),
    .wr_valid (wr_valid),
    .wr_key   (r_key),
    .wr_val   (r_val),
    .ptr_adv  (ptr_adv && (state == LOOKUP)),
    .clr_en   (state == CLR),
    .clr_set  (cnt)
  );
endmodule

// File: tb/tb_h_assoc.sv
// tb_h_assoc: directed checks of the hash table, reject and evict variants side by side
module tb_h_assoc;
  import h_pkg::*;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  opcode_t     cmd_opcode = NOP;
  logic [31:0] cmd_k = '0;
  logic [31:0] cmd_v = '0;
  logic        force3 = 1'b0;
  logic        cmd_rdy0, cmd_rdy1, rsp_vld0, rsp_vld1;
  status_t     rsp_status0, rsp_status1;
  logic [31:0] rsp_v0, rsp_v1, hk0, hk1;
  logic [3:0]  hh0, hh1;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  assign hh0 = force3 ? 4'd3 : hk0[3:0];
  assign hh1 = force3 ? 4'd3 : hk1[3:0];
  h_assoc #(.EVICT_EN(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy0),
    .cmd_opcode(cmd_opcode), .cmd_k(cmd_k), .cmd_v(cmd_v), .rsp_vld(rsp_vld0),
    .rsp_status(rsp_status0), .rsp_v(rsp_v0), .hash_k(hk0), .hash_h(hh0)
  );
  h_assoc #(.EVICT_EN(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy1),
    .cmd_opcode(cmd_opcode), .cmd_k(cmd_k), .cmd_v(cmd_v), .rsp_vld(rsp_vld1),
    .rsp_status(rsp_status1), .rsp_v(rsp_v1), .hash_k(hk1), .hash_h(hh1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic do_cmd(input opcode_t op, input logic [31:0] k, input logic [31:0] v,
                        input status_t s0, input logic [31:0] v0,
                        input status_t s1, input logic [31:0] v1, input string tag);
    cmd_vld = 1'b1;
    cmd_opcode = op;
    cmd_k = k;
    cmd_v = v;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    chk({tag, ".busy"}, {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b0000);
    @(posedge clk); #1;
    chk({tag, ".vld"}, {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b1111);
    chk({tag, ".st0"}, rsp_status0, s0);
    chk({tag, ".v0"}, rsp_v0, v0);
    chk({tag, ".st1"}, rsp_status1, s1);
    chk({tag, ".v1"}, rsp_v1, v1);
  endtask
  task automatic check_idle_after_reset(input string tag);
    chk({tag, ".rdy_vld"}, {cmd_rdy0, cmd_rdy1, rsp_vld0, rsp_vld1}, 4'b1100);
    chk({tag, ".st"}, {rsp_status0, rsp_status1}, {OK, OK});
    chk({tag, ".v"}, {rsp_v0, rsp_v1}, 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    check_idle_after_reset("reset");
    arst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(QUERY,  32'h11, 32'h0,  MISS, 32'h0,  MISS, 32'h0,  "q_empty");
    do_cmd(INSERT, 32'h11, 32'hAA, OK,   32'h0,  OK,   32'h0,  "ins_aa");
    do_cmd(QUERY,  32'h11, 32'h0,  HIT,  32'hAA, HIT,  32'hAA, "q_aa");
    do_cmd(INSERT, 32'h11, 32'hBB, HIT,  32'hAA, HIT,  32'hAA, "ins_bb");
    cmd_vld = 1'b1;
    cmd_opcode = NOP;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    chk("nop.c1", {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b0011);
    @(posedge clk); #1;
    chk("nop.c2", {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b0011);
    do_cmd(opcode_t'(3'd7), 32'h11, 32'h0, BADOP, 32'h0, BADOP, 32'h0, "badop");
    do_cmd(QUERY,  32'h11, 32'h0,  HIT,  32'hBB, HIT,  32'hBB, "q_bb");
    force3 = 1'b1;
    do_cmd(INSERT, 32'h100, 32'hA1, OK, 32'h0, OK, 32'h0, "fill0");
    do_cmd(INSERT, 32'h200, 32'hA2, OK, 32'h0, OK, 32'h0, "fill1");
    do_cmd(INSERT, 32'h300, 32'hA3, OK, 32'h0, OK, 32'h0, "fill2");
    do_cmd(INSERT, 32'h400, 32'hA4, OK, 32'h0, OK, 32'h0, "fill3");
    do_cmd(INSERT, 32'h500, 32'h55, FULL, 32'h0, EVICT, 32'hA1, "full_a");
    do_cmd(INSERT, 32'h600, 32'h66, FULL, 32'h0, EVICT, 32'hA2, "full_b");
    do_cmd(QUERY,  32'h100, 32'h0, HIT,  32'hA1, MISS, 32'h0,  "q_evicted");
    do_cmd(QUERY,  32'h500, 32'h0, MISS, 32'h0,  HIT,  32'h55, "q_new");
    do_cmd(QUERY,  32'h400, 32'h0, HIT,  32'hA4, HIT,  32'hA4, "q_kept");
    force3 = 1'b0;
    do_cmd(DELETE, 32'h11, 32'h0, HIT,  32'hBB, HIT,  32'hBB, "del_hit");
    do_cmd(QUERY,  32'h11, 32'h0, MISS, 32'h0,  MISS, 32'h0,  "q_deleted");
    do_cmd(DELETE, 32'h11, 32'h0, MISS, 32'h0,  MISS, 32'h0,  "del_miss");
    do_cmd(INSERT, 32'h21, 32'h21, OK, 32'h0, OK, 32'h0, "clr_fill1");
    do_cmd(INSERT, 32'h22, 32'h22, OK, 32'h0, OK, 32'h0, "clr_fill2");
    do_cmd(INSERT, 32'h24, 32'h24, OK, 32'h0, OK, 32'h0, "clr_fill4");
    cmd_vld = 1'b1;
    cmd_opcode = CLEAR;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    c = 0;
    while (!cmd_rdy0 && c < 64) begin
      c++;
      @(posedge clk); #1;
    end
    chk("clear.busy_cycles", c, 16);
    chk("clear.vld", {rsp_vld0, rsp_vld1, cmd_rdy1}, 3'b111);
    chk("clear.st", {rsp_status0, rsp_status1}, {OK, OK});
    do_cmd(QUERY, 32'h21, 32'h0, MISS, 32'h0, MISS, 32'h0, "q_clr1");
    do_cmd(QUERY, 32'h22, 32'h0, MISS, 32'h0, MISS, 32'h0, "q_clr2");
    do_cmd(QUERY, 32'h24, 32'h0, MISS, 32'h0, MISS, 32'h0, "q_clr4");
    force3 = 1'b1;
    do_cmd(QUERY, 32'h400, 32'h0, MISS, 32'h0, MISS, 32'h0, "q_clr3");
    force3 = 1'b0;
    do_cmd(INSERT, 32'h3F, 32'h3F, OK, 32'h0, OK, 32'h0, "ins_s15");
    cmd_vld = 1'b1;
    cmd_opcode = CLEAR;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #2;
    check_idle_after_reset("rst_clr");
    #2;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_clr.quiet", {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b0011);
    do_cmd(QUERY,  32'h3F, 32'h0,  MISS, 32'h0,  MISS, 32'h0,  "q_rst_clr");
    do_cmd(INSERT, 32'h4E, 32'h4E, OK,   32'h0,  OK,   32'h0,  "ins_4e");
    do_cmd(QUERY,  32'h4E, 32'h0,  HIT,  32'h4E, HIT,  32'h4E, "q_4e");
    cmd_vld = 1'b1;
    cmd_opcode = QUERY;
    cmd_k = 32'h4E;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    arst_n = 1'b0;
    #2;
    check_idle_after_reset("rst_lookup");
    #2;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_lookup.quiet1", {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b0011);
    @(posedge clk); #1;
    chk("rst_lookup.quiet2", {rsp_vld0, rsp_vld1, cmd_rdy0, cmd_rdy1}, 4'b0011);
    do_cmd(QUERY, 32'h4E, 32'h0, MISS, 32'h0, MISS, 32'h0, "q_rst_lookup");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/h_assoc.md
H_ASSOC -- requirements
Module: h_assoc

Interface
REQ-001 SHALL have parameter N_SETS, default 16, number of hash sets (power of 2, >=2).
REQ-002 SHALL have parameter N_WAYS, default 4, entries per set (>=1).
REQ-003 SHALL have parameter K_W, default 32, key width.
REQ-004 SHALL have parameter V_W, default 32, value width.
REQ-005 SHALL have parameter EVICT_EN, default 0, 1 = replace on a full set, 0 = reject on a full set.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port arst_n, input, 1, reset; one clock, reset asynchronous active-low.
REQ-008 SHALL have port cmd_vld, input, 1, command valid.
REQ-009 SHALL have port cmd_rdy, output, 1, command ready.
REQ-010 SHALL have port cmd_opcode, input, opcode_t, operation: NOP/INSERT/DELETE/QUERY/CLEAR.
REQ-011 SHALL have port cmd_k, input, K_W, key.
REQ-012 SHALL have port cmd_v, input, V_W, value (INSERT only).
REQ-013 SHALL have port rsp_vld, output, 1, one-cycle response pulse; no backpressure.
REQ-014 SHALL have port rsp_status, output, status_t, result: OK/HIT/MISS/FULL/EVICT/BADOP.
REQ-015 SHALL have port rsp_v, output, V_W, returned value.
REQ-016 SHALL have port hash_k, output, K_W, key to the user hash function.
REQ-017 SHALL have port hash_h, input, log2(N_SETS), set index, combinational from hash_k in the same cycle.

Function
REQ-018 SHALL accept a command on a clk edge where cmd_vld and cmd_rdy are both 1.
- hash_k SHALL equal cmd_k combinationally.
- hash_h, opcode, key and value SHALL be registered at acceptance.
REQ-019 SHALL use FSM states IDLE, LOOKUP, RESP and CLR.
- IDLE: cmd_rdy=1; goes to LOOKUP on an accepted non-NOP, non-CLEAR command, and to CLR on an accepted CLEAR.
- LOOKUP: cmd_rdy=0; goes to RESP.
- RESP: cmd_rdy=1 and rsp_vld=1; may accept a new command in this cycle.
REQ-020 SHALL treat an accepted NOP as producing no response and no state change.
REQ-021 SHALL, in LOOKUP, compare the key against all valid ways of set hash_h in parallel.
- If more than one way matches, the lowest-index match wins.
REQ-022 QUERY: on a hit, rsp_status=HIT and rsp_v=the stored value; on a miss, rsp_status=MISS and rsp_v=0.
REQ-023 INSERT on a hit SHALL overwrite the value; rsp_status=HIT, rsp_v=the old value.
REQ-024 INSERT on a miss with an invalid way SHALL write the lowest-index invalid way; rsp_status=OK, rsp_v=0.
REQ-025 INSERT on a miss with the set full:
- EVICT_EN=0: no write; rsp_status=FULL.
- EVICT_EN=1: overwrite the way at the set's round-robin pointer; rsp_status=EVICT, rsp_v=the evicted value.
- Evictions SHALL advance that pointer by 1, wrapping at N_WAYS-1 to 0.
REQ-026 DELETE: on a hit, clear the valid bit; rsp_status=HIT, rsp_v=the old value. On a miss, rsp_status=MISS.
REQ-027 SHALL perform all array writes on the edge ending LOOKUP.
- A command accepted in RESP SHALL observe that write.
REQ-028 Latency: rsp_vld SHALL occur exactly 2 cycles after acceptance; throughput is 1 command per 2 cycles.
REQ-029 CLEAR SHALL spend N_SETS cycles in CLR.
- Each cycle it zeroes the valid bits and round-robin pointer of one set, counting 0..N_SETS-1.
- It then enters RESP with rsp_status=OK, i.e. rsp_vld N_SETS+1 cycles after acceptance.
REQ-030 An undefined opcode SHALL produce rsp_status=BADOP at latency 2 with no state change.
REQ-031 rsp_status and rsp_v SHALL hold their last values when rsp_vld=0.

Reset
REQ-032 On arst_n low, all of the following SHALL clear immediately, including mid-operation or mid-CLEAR:
- state=IDLE, cmd_rdy=1, rsp_vld=0, rsp_status=OK, rsp_v=0;
- all valid bits, round-robin pointers and the CLR counter=0.
REQ-033 Key and value arrays SHALL NOT be reset.
REQ-034 Any in-flight command SHALL be discarded by reset, with no response.

Structure
REQ-035 opcode_t and status_t SHALL live in h_pkg; default N_SETS/N_WAYS/K_W/V_W SHALL live in cfg_pkg.
REQ-036 The set storage SHALL be the sub-module h_assoc_tbl.
- It holds valid, key, value and the round-robin pointer per set.
- It has one combinational read port and one write port.
- It supports whole-set clear.
REQ-037 h_assoc SHALL contain the FSM, way compare, allocation/eviction selection and the response register.

Verification
REQ-038 Reset, then QUERY k=0x11 -> MISS, rsp_v=0, at acceptance+2.
REQ-039 INSERT k=0x11 v=0xAA, then QUERY 0x11 -> OK then HIT with rsp_v=0xAA; INSERT 0x11 v=0xBB -> HIT, rsp_v=0xAA.
REQ-040 EVICT_EN=0, hash forced to 3: five INSERTs -> four OK, the fifth FULL; EVICT_EN=1 -> the fifth is EVICT with way 0's value, and the pointer becomes 1.
REQ-041 DELETE a present key -> HIT with the old value, then QUERY -> MISS; DELETE again -> MISS.
REQ-042 Fill 3 sets, CLEAR -> cmd_rdy=0 for 16 cycles, rsp OK at +17, then all QUERYs -> MISS.
REQ-043 Assert arst_n low in the middle of CLEAR and of LOOKUP -> no rsp_vld, cmd_rdy=1 and table empty after release.
